rs_issue_scheduler: RTL and testbench
=====================================

# rs_issue_scheduler

Issue scheduler between the 16-entry reservation station and the single ALU. Each cycle it selects one ready station entry, presents its index to the ALU with a valid/busy handshake, and pulses a grant so the station frees that entry. It holds the issued slot across ALU back-pressure, masks the just-granted entry, flushes on `rollback`, and counts accepted issues.

## Interface
- `ENTRIES`, 16, number of reservation-station slots
- `IDX_W`, 4, slot index width (log2 ENTRIES)
- `ROB_W`, 4, ROB tag width
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `rdy`  in  1  global enable; 0 freezes all state and outputs
- `rollback`  in  1  synchronous flush from ROB
- `in_ready_vec`  in  ENTRIES  bit i = slot i used and both operands available
- `in_rob_tags`  in  ENTRIES*ROB_W  ROB tag of slot i at bits [i*ROB_W +: ROB_W]
- `in_rob_head`  in  ROB_W  current ROB head tag
- `alu_busy`  in  1  ALU cannot accept this cycle
- `out_valid`  out  1  `out_idx` holds an instruction for the ALU
- `out_idx`  out  IDX_W  selected slot
- `out_grant`  out  1  one-cycle pulse; station frees slot `out_idx` at this edge
- `out_issue_count`  out  16  accepted issues, wraps at 65535 -> 0

## Operation
- States: IDLE, ISSUE, STALL, FLUSH. Reset: IDLE.
- Candidate set = `in_ready_vec` & ~mask; mask = one-hot(`out_idx`) while `out_grant`=1, else 0.
- Pick (combinational): policy per Configuration; none if candidate set empty.
- IDLE: candidate -> load `out_idx`, `out_valid`=1, `out_grant`=1, go ISSUE; else stay.
- ISSUE/STALL, `alu_busy`=0 (accepted): count+1; candidate -> load new pick, `out_grant`=1, ISSUE; none -> `out_valid`=0, IDLE.
- ISSUE/STALL, `alu_busy`=1: hold `out_valid`/`out_idx`, `out_grant`=0, go STALL.
- Round-robin pointer: after each pick, pointer = (picked+1) mod ENTRIES; search starts at pointer, wraps 15->0.
- `rollback`=1 (any state, rdy=1): `out_valid`=0, `out_grant`=0, pointer=0, go FLUSH; current issue not counted even if `alu_busy`=0.
- FLUSH: ignore `in_ready_vec` one cycle, go IDLE.
- `rdy`=0: no state, pointer, count or output change; `rollback` ignored.

## Timing
- Reset (async assert, sync to clock on release): `out_valid`=0, `out_idx`=0, `out_grant`=0, `out_issue_count`=0, pointer=0.
- Latency: ready bit set before edge N -> `out_valid`/`out_grant` high after edge N (1 cycle).
- Back-to-back: one issue per cycle while ALU not busy and candidates exist.
- `out_grant` never high for two consecutive cycles with the same `out_idx` unless the slot was re-readied.
- `rollback` + `alu_busy` same cycle: rollback wins.
- After rollback: earliest new `out_valid` is 2 edges later (FLUSH then IDLE pick).

## Configuration
- `RS_SCHED_OLDEST_EN` defined: oldest-first; age_i = (tag_i - `in_rob_head`) mod 2^ROB_W; smallest age wins, ties -> lowest index; pointer still updated but unused.
- Not defined: round-robin only; `in_rob_tags`/`in_rob_head` ignored.

## Test plan
- Reset: `rst_n`=0 mid-STALL -> all outputs 0 immediately, count 0; release -> IDLE.
- RR: ready=16'h8001, busy=0 -> picks 0 then 15 then 0; ready=16'h0000 after -> `out_valid`=0 next cycle.
- Stall: ready=16'h0010, busy=1 for 3 cycles -> `out_idx`=4 held, `out_grant` high only first cycle, count increments once when busy drops.
- Mask: ready=16'h0004 held 2 cycles -> single grant of slot 2, no duplicate.
- Rollback: during ISSUE with busy=0 -> `out_valid`=0 next edge, count unchanged, no issue for one FLUSH cycle.
- Oldest (`RS_SCHED_OLDEST_EN`): head=14, slot3 tag=1, slot9 tag=15 -> picks 9; rdy=0 two cycles -> outputs frozen.

Source files
------------

// File: rtl/rs_issue_scheduler.sv
// rs_issue_scheduler: picks one ready RS slot per cycle for the ALU with valid/busy handshake and grant pulse.
// Define RS_SCHED_OLDEST_EN for oldest-first selection by ROB age; default is round-robin.
module rs_issue_scheduler #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int ROB_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rdy,
  input  logic                     rollback,
  input  logic [ENTRIES-1:0]       in_ready_vec,
  input  logic [ENTRIES*ROB_W-1:0] in_rob_tags,
  input  logic [ROB_W-1:0]         in_rob_head,
  input  logic                     alu_busy,
  output logic                     out_valid,
  output logic [IDX_W-1:0]         out_idx,
  output logic                     out_grant,
  output logic [15:0]              out_issue_count
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, STALL = 2'd2, FLUSH = 2'd3;
  logic [1:0]         state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   pick;
  logic               found;
  logic [ENTRIES-1:0] cand;
  // The slot granted last edge is still visible in the ready vector this cycle
  assign cand = in_ready_vec & ~(out_grant ? ENTRIES'(1) << out_idx : '0);
`ifdef RS_SCHED_OLDEST_EN
  logic [ROB_W-1:0] age, best;
  logic             unused_ptr;
  assign unused_ptr = ^ptr;
  always_comb begin
    found = 1'b0;
    pick  = '0;
    best  = '1;
    age   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      age = in_rob_tags[i*ROB_W +: ROB_W] - in_rob_head;
      if (cand[i] && (!found || age < best)) begin
        found = 1'b1;
        pick  = IDX_W'(i);
        best  = age;
      end
    end
  end
`else
  logic unused_tags;
  assign unused_tags = ^{in_rob_tags, in_rob_head};
  // Descending scan so the slot nearest the pointer wins
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = ENTRIES - 1; k >= 0; k--) begin
      if (cand[ptr + IDX_W'(k)]) begin
        found = 1'b1;
        pick  = ptr + IDX_W'(k);
      end
    end
  end
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      ptr             <= '0;
      out_valid       <= 1'b0;
      out_idx         <= '0;
      out_grant       <= 1'b0;
      out_issue_count <= '0;
    end else if (rdy) begin
      if (rollback) begin
        state     <= FLUSH;
        ptr       <= '0;
        out_valid <= 1'b0;
        out_grant <= 1'b0;
      end else if (state == FLUSH) begin
        state <= IDLE;
      end else if (state != IDLE && alu_busy) begin
        state     <= STALL;
        out_grant <= 1'b0;
      end else begin
        if (state != IDLE) out_issue_count <= out_issue_count + 16'd1;
        if (found) begin
          state     <= ISSUE;
          out_idx   <= pick;
          ptr       <= pick + IDX_W'(1);
          out_valid <= 1'b1;
          out_grant <= 1'b1;
        end else begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_grant <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_rs_issue_scheduler.sv
// tb_rs_issue_scheduler: directed and random stimulus checked against a behavioural scheduler model.
module tb_rs_issue_scheduler;
  logic        clk = 0, rst_n = 0, rdy = 1, rollback = 0, alu_busy = 0;
  logic [15:0] ready = 0;
  logic [63:0] tags = 0;
  logic [3:0]  head = 0;
  logic        out_valid, out_grant;
  logic [3:0]  out_idx;
  logic [15:0] out_issue_count;
  int total = 0, bad = 0;
  logic        m_valid = 0, m_grant = 0, m_flush = 0;
  logic [3:0]  m_idx = 0, m_ptr = 0;
  logic [15:0] m_cnt = 0;

  rs_issue_scheduler dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .rollback(rollback),
    .in_ready_vec(ready), .in_rob_tags(tags), .in_rob_head(head), .alu_busy(alu_busy),
    .out_valid(out_valid), .out_idx(out_idx), .out_grant(out_grant),
    .out_issue_count(out_issue_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Returns {found, slot}
  function automatic logic [4:0] m_pick(input logic [15:0] c);
    int best, age, j;
    logic [4:0] r;
    best = 99;
    r = 0;
`ifdef RS_SCHED_OLDEST_EN
    for (int i = 0; i < 16; i++) begin
      age = (int'(tags[i*4 +: 4]) - int'(head) + 16) % 16;
      if (c[i] && age < best) begin best = age; r = {1'b1, 4'(i)}; end
    end
`else
    for (int k = 15; k >= 0; k--) begin
      j = (int'(m_ptr) + k) % 16;
      if (c[j]) r = {1'b1, 4'(j)};
    end
`endif
    return r;
  endfunction

  task automatic model_step();
    logic [4:0] p;
    logic [15:0] c;
    if (!rdy) return;
    c = ready & ~(m_grant ? (16'd1 << m_idx) : 16'd0);
    p = m_pick(c);
    if (rollback) begin
      m_valid = 0; m_grant = 0; m_ptr = 0; m_flush = 1;
    end else if (m_flush) begin
      m_flush = 0;
    end else if (m_valid && alu_busy) begin
      m_grant = 0;
    end else begin
      if (m_valid) m_cnt++;
      m_valid = p[4];
      m_grant = p[4];
      if (p[4]) begin m_idx = p[3:0]; m_ptr = p[3:0] + 4'd1; end
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("valid", out_valid, m_valid);
    chk("grant", out_grant, m_grant);
    chk("idx", out_idx, m_idx);
    chk("count", out_issue_count, m_cnt);
  endtask

  task automatic model_reset();
    m_valid = 0; m_grant = 0; m_flush = 0; m_idx = 0; m_ptr = 0; m_cnt = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1;
    chk("rst_valid", out_valid, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_grant", out_grant, 0);
    chk("rst_count", out_issue_count, 0);
`ifndef RS_SCHED_OLDEST_EN
    ready = 16'h8001;
    cyc(); chk("rr_first", out_idx, 0);
    cyc(); chk("rr_second", out_idx, 15);
    cyc(); chk("rr_third", out_idx, 0);
    ready = 0;
    cyc(); chk("rr_empty", out_valid, 0);
`endif
    ready = 16'h0010;
    cyc(); chk("st_idx", out_idx, 4); chk("st_grant0", out_grant, 1);
    ready = 0; alu_busy = 1;
    for (int i = 0; i < 3; i++) begin
      cyc(); chk("st_hold", out_idx, 4); chk("st_nogrant", out_grant, 0); chk("st_valid", out_valid, 1);
    end
    alu_busy = 0;
    cyc(); chk("st_valid_drop", out_valid, 0);
    ready = 16'h0004;
    cyc(); chk("mk_idx", out_idx, 2); chk("mk_grant", out_grant, 1);
    cyc(); chk("mk_nodup", out_grant, 0);
    ready = 0;
    cyc();
    ready = 16'hffff;
    cyc(); chk("rb_pre", out_valid, 1);
    rollback = 1;
    cyc(); chk("rb_valid", out_valid, 0); chk("rb_count", out_issue_count, m_cnt);
    rollback = 0;
    cyc(); chk("rb_flush", out_valid, 0);
    cyc(); chk("rb_resume", out_valid, 1); chk("rb_idx0", out_idx, 0);
`ifdef RS_SCHED_OLDEST_EN
    ready = 0; cyc();
    head = 14; tags = 0; tags[3*4 +: 4] = 1; tags[9*4 +: 4] = 15; ready = 16'h0208;
    cyc(); chk("old_pick", out_idx, 9);
`endif
    ready = 0; cyc();
    ready = 16'h0100;
    cyc(); chk("fz_pre", out_idx, 8);
    rdy = 0; rollback = 1; ready = 16'hffff; alu_busy = 0;
    for (int i = 0; i < 2; i++) begin
      cyc(); chk("fz_idx", out_idx, 8); chk("fz_grant", out_grant, 1); chk("fz_valid", out_valid, 1);
    end
    rdy = 1; rollback = 0; ready = 0; alu_busy = 1;
    cyc(); cyc();
    chk("rs_pre_stall", out_valid, 1);
    rst_n = 0;
    #1;
    chk("rs_async_valid", out_valid, 0);
    chk("rs_async_grant", out_grant, 0);
    chk("rs_async_idx", out_idx, 0);
    chk("rs_async_count", out_issue_count, 0);
    @(negedge clk);
    rst_n = 1;
    alu_busy = 0;
    model_reset();
    for (int n = 0; n < 4000; n++) begin
      ready    = $urandom_range(3) == 0 ? 16'h0 : 16'($urandom & $urandom);
      tags     = {$urandom, $urandom};
      head     = 4'($urandom);
      alu_busy = $urandom_range(9) < 3;
      rollback = $urandom_range(19) == 0;
      rdy      = $urandom_range(9) != 0;
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
